// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   - funct3 encodings of the RV M-extension operations
//   - FSM state enum used by muldiv_unit
//   - helpers deciding operand signedness from funct3
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // rs1 is interpreted as two's complement for these operations.
  function automatic logic f3_a_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is interpreted as two's complement for these operations.
  function automatic logic f3_b_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix -- sign/magnitude front end and final negation.
//   i_funct3        : operation, selects which operands are signed
//   i_op_a, i_op_b  : raw operands
//   i_val, i_neg    : unsigned iteration result and whether to negate it
//   o_mag_a/o_mag_b : operand magnitudes fed to the iterative core
//   o_sign_a/o_sign_b : effective operand signs (0 for unsigned operands)
//   o_val           : i_val, two's-complement negated when i_neg is set
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_op_a,
  input  logic [XLEN-1:0]   i_op_b,
  input  logic [2*XLEN-1:0] i_val,
  input  logic              i_neg,
  output logic [XLEN-1:0]   o_mag_a,
  output logic [XLEN-1:0]   o_mag_b,
  output logic              o_sign_a,
  output logic              o_sign_b,
  output logic [2*XLEN-1:0] o_val
);

  // Operand magnitudes; the most-negative value maps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    o_sign_a = f3_a_signed(i_funct3) & i_op_a[XLEN-1];
    o_sign_b = f3_b_signed(i_funct3) & i_op_b[XLEN-1];
    if (o_sign_a) begin
      o_mag_a = -i_op_a;
    end else begin
      o_mag_a = i_op_a;
    end
    if (o_sign_b) begin
      o_mag_b = -i_op_b;
    end else begin
      o_mag_b = i_op_b;
    end
  end

  // Final result sign correction.
  always_comb begin
    if (i_neg) begin
      o_val = -i_val;
    end else begin
      o_val = i_val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV M-extension multiply/divide, one bit per cycle.
//   clk, rst (sync, active-high)
//   in_valid/in_ready, funct3, op_a, op_b : request handshake and operands
//   out_valid/out_ready, result, illegal  : response handshake and data
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// funct3[2]=1 requests complete at once with result=0 and illegal=1.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [XLEN-1:0] r_hi;   // product high half / partial remainder
  logic [XLEN-1:0] r_lo;   // multiplier / dividend shifting into quotient
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  logic [2:0]        w_sf_f3;
  logic [XLEN-1:0]   w_sf_a;
  logic [XLEN-1:0]   w_sf_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [2*XLEN-1:0] w_fix_in;
  logic              w_fix_neg;
  logic [2*XLEN-1:0] w_fix_out;
  logic [XLEN:0]     w_add;
  logic [XLEN-1:0]   w_mul_hi_n;
  logic [XLEN-1:0]   w_mul_lo_n;
  logic [XLEN-1:0]   w_hi_n;
  logic [XLEN-1:0]   w_lo_n;
  logic [XLEN-1:0]   w_res_final;

  // In IDLE the sign unit looks at the live request so the first shift
  // register load is already a magnitude; afterwards it uses the latched copy.
  always_comb begin
    if (r_state == IDLE) begin
      w_sf_f3 = funct3;
      w_sf_a  = op_a;
      w_sf_b  = op_b;
    end else begin
      w_sf_f3 = r_funct3;
      w_sf_a  = r_op_a;
      w_sf_b  = r_op_b;
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_funct3 (w_sf_f3),
    .i_op_a   (w_sf_a),
    .i_op_b   (w_sf_b),
    .i_val    (w_fix_in),
    .i_neg    (w_fix_neg),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_sign_a (w_sign_a),
    .o_sign_b (w_sign_b),
    .o_val    (w_fix_out)
  );

  // Shift-add step: conditionally add multiplicand, then shift {hi,lo} right.
  always_comb begin
    if (r_lo[0]) begin
      w_add = {1'b0, r_hi} + {1'b0, w_mag_a};
    end else begin
      w_add = {1'b0, r_hi};
    end
    w_mul_hi_n = w_add[XLEN:1];
    w_mul_lo_n = {w_add[0], r_lo[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_div_hi_n;
  logic [XLEN-1:0] w_div_lo_n;

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  // The kept difference is always below the divisor, so XLEN bits suffice.
  always_comb begin
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift[XLEN-1:0] - w_mag_b;
    if (w_shift >= {1'b0, w_mag_b}) begin
      w_div_hi_n = w_diff;
      w_div_lo_n = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_div_hi_n = w_shift[XLEN-1:0];
      w_div_lo_n = {r_lo[XLEN-2:0], 1'b0};
    end
  end
`endif

  // Select next shift-register contents and the value/sign for final fix-up.
  always_comb begin
    w_hi_n    = w_mul_hi_n;
    w_lo_n    = w_mul_lo_n;
    w_fix_in  = {w_mul_hi_n, w_mul_lo_n};
    w_fix_neg = w_sign_a ^ w_sign_b;
`ifdef MULDIV_DIV_EN
    if (r_funct3[2]) begin
      w_hi_n = w_div_hi_n;
      w_lo_n = w_div_lo_n;
      if (r_funct3[1]) begin
        // remainder takes the dividend's sign
        w_fix_in  = {{XLEN{1'b0}}, w_div_hi_n};
        w_fix_neg = w_sign_a;
      end else begin
        w_fix_in  = {{XLEN{1'b0}}, w_div_lo_n};
        w_fix_neg = w_sign_a ^ w_sign_b;
      end
    end else begin
      w_hi_n = w_mul_hi_n;
      w_lo_n = w_mul_lo_n;
    end
`endif
  end

  // MUL and divide results live in the low half, MULH* in the high half.
  always_comb begin
    if ((r_funct3 == F3_MUL) || r_funct3[2]) begin
      w_res_final = w_fix_out[XLEN-1:0];
    end else begin
      w_res_final = w_fix_out[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_funct3    <= F3_MUL;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_funct3   <= funct3;
            r_op_a     <= op_a;
            r_op_b     <= op_b;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_in_ready <= 1'b0;
`ifdef MULDIV_DIV_EN
            if (funct3[2] && (op_b == '0)) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= funct3[1] ? op_a : {XLEN{1'b1}};
            end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                         (op_a == MOST_NEG) && (op_b == {XLEN{1'b1}})) begin
              // signed overflow: quotient saturates to op_a, remainder 0
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= funct3[1] ? {XLEN{1'b0}} : op_a;
            end else begin
              r_state <= CALC;
              r_lo    <= funct3[2] ? w_mag_a : w_mag_b;
            end
            r_illegal <= 1'b0;
`else
            if (funct3[2]) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_illegal   <= 1'b1;
            end else begin
              r_state <= CALC;
              r_lo    <= w_mag_b;
            end
`endif
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          // runs 0..XLEN, so CW bits never wrap
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res_final;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_result    <= '0;
          r_illegal   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit (XLEN=32).
// Divider vectors are used when MULDIV_DIV_EN is defined, otherwise the
// illegal-op response is checked instead.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the response, check latency/result/illegal,
  // then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;  // must be ignored after acceptance
    op_b     = 32'h1234_5678;
    lat = 1;
    if (exp_lat > 1) begin
      check({tag, "_busy"}, {62'd0, in_ready, out_valid}, 64'd0);
      check({tag, "_busy_res"}, 64'(result), 64'd0);
    end
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    funct3    = 3'b000;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);

    // multiply family
    run_op("mul_7_m3",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mulhu_max",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("mulhsu_m1_2", F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, 33);
    run_op("mulh_m1_m1",  F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
    run_op("mulh_m2_3",   F3_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0, 33);

`ifdef MULDIV_DIV_EN
    run_op("div_m7_2",    F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33);
    run_op("rem_m7_2",    F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33);
    run_op("rem_7_m2",    F3_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 33);
    run_op("divu_100_7",  F3_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 33);
    run_op("remu_100_7",  F3_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 33);
    run_op("divu_100_0",  F3_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 1);
    run_op("remu_100_0",  F3_REMU, 32'd100,       32'd0,         32'd100,       1'b0, 1);
    run_op("div_ovf",     F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run_op("rem_ovf",     F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1);
    run_op("divu_nonovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 33);
`else
    run_op("divu_illegal", F3_DIVU, 32'd10, 32'd3, 32'd0, 1'b1, 1);
    run_op("rem_illegal",  F3_REM,  32'd7,  32'd0, 32'd0, 1'b1, 1);
`endif

    // consumer stall in DONE: output must hold and handshake exactly once
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = F3_MUL;
    op_a     = 32'd5;
    op_b     = 32'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stall_lat", 64'(lat), 64'd33);
    for (int k = 0; k < 5; k++) begin
      check("stall_res", 64'(result), 64'd30);
      check("stall_flags", {62'd0, in_ready, out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall_release", {62'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk);
    #1;
    check("stall_single", 64'(out_valid), 64'd0);

    // reset in CALC cycle 10 discards the operation
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = F3_MUL;
    op_a     = 32'd9;
    op_b     = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_no_result", 64'(seen), 64'd0);
    run_op("mul_after_rst", F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port funct3, input, 3, RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a, input, XLEN, rs1 operand (dividend/multiplicand).
REQ-008 SHALL have port op_b, input, XLEN, rs2 operand (divisor/multiplier).
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, XLEN, operation result.
REQ-012 SHALL have port illegal, output, 1, qualified by out_valid; op not supported in this build.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept on in_valid&&in_ready, registering funct3, op_a and op_b; inputs are ignored outside acceptance cycles.
REQ-015 SHALL transition IDLE->CALC on acceptance, except special cases (REQ-019..020), which go IDLE->DONE.
REQ-016 SHALL iterate one bit per cycle for exactly XLEN cycles in CALC, then enter DONE; acceptance at cycle 0 gives out_valid first high at cycle XLEN+1.
REQ-017 SHALL compute multiply with shift-add on magnitudes into a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits; signedness: MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned; final product negated when operand signs differ.
REQ-018 SHALL compute divide with a restoring algorithm on magnitudes; quotient sign = sign(a) xor sign(b), remainder sign = sign(a) for signed ops.
REQ-019 SHALL, for divisor zero, return quotient all-ones (DIV, DIVU) and remainder = op_a (REM, REMU), out_valid at cycle 1.
REQ-020 SHALL, for DIV/REM with op_a = most-negative and op_b = all-ones, return quotient = op_a and remainder 0, out_valid at cycle 1.
REQ-021 SHALL hold out_valid, result and illegal stable in DONE until out_valid&&out_ready, then return to IDLE; earliest next acceptance is the following cycle.
REQ-022 SHALL drive result 0 and illegal 0 whenever out_valid is 0.
REQ-023 SHALL size the iteration counter as $clog2(XLEN)+1 bits with no wrap inside CALC.

Reset
REQ-024 SHALL, on rst high at any clock edge, enter IDLE with out_valid=0, result=0, illegal=0, counter=0, and in_ready=1 in the following cycle.
REQ-025 SHALL discard any in-flight operation on reset without producing a result.

Configuration
REQ-026 SHALL compile the divider (REQ-018..020) only when MULDIV_DIV_EN is defined; with it defined, illegal is constant 0.
REQ-027 SHALL, without MULDIV_DIV_EN, send funct3[2]=1 requests IDLE->DONE with result=0, illegal=1, out_valid at cycle 1, and remove divider logic entirely; multiply behaviour unchanged.

Structure
REQ-028 SHALL take funct3 encodings as localparams and the FSM state enum from shared package muldiv_pkg.
REQ-029 SHALL place operand sign/magnitude conversion and final negation in sub-module muldiv_sign_fix; FSM, counter and shift registers remain in muldiv_unit.

Verification (XLEN=32, MULDIV_DIV_EN defined unless stated)
REQ-030 SHALL test MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid first at cycle 33; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-031 SHALL test DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM same operands -> 0xFFFFFFFF at cycle 33; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100 at cycle 1.
REQ-032 SHALL test DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both at cycle 1.
REQ-033 SHALL test out_ready held low 5 cycles in DONE -> result stable, in_ready 0 throughout, single handshake on release.
REQ-034 SHALL test rst asserted in CALC cycle 10 -> next cycle in_ready=1, out_valid=0; a new MUL 3*4 then returns 12 at cycle 33.
REQ-035 SHALL test, without MULDIV_DIV_EN, DIVU 10/3 -> out_valid at cycle 1 with illegal=1, result=0; MUL 3*4 unchanged -> 12.
